// File: rtl/corelet_ctrl.sv
// Tile-job sequencer: drives the corelet inst bundle through weight fetch/load,
// activation fetch/execute, OFIFO drain and delayed pmem writeback.
module corelet_ctrl #(
  parameter int unsigned col      = 8,
  parameter int unsigned row      = 8,
  parameter int unsigned addr_bw  = 11,
  parameter int unsigned LOAD_GAP = 16,
  parameter int unsigned WB_LAT   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [addr_bw-1:0] n_act,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic [addr_bw-1:0] p_base,
  input  logic [1:0]         sfu_mode_i,
  input  logic               ofifo_valid,
  output logic [35:0]        inst,
  output logic               busy,
  output logic               done
);

  localparam logic [35:0] IdleInst = 36'h1_800C_0000;
  localparam int unsigned LenMax   = (col > row) ? ((col > LOAD_GAP) ? col : LOAD_GAP)
                                                 : ((row > LOAD_GAP) ? row : LOAD_GAP);
  // Counter must hold n_act+1 as well as any fixed phase length.
  localparam int unsigned CntW     = ((addr_bw + 1) > $clog2(LenMax + 1)) ? (addr_bw + 1)
                                                                          : $clog2(LenMax + 1);
  localparam int unsigned PipeW    = WB_LAT * addr_bw;

  typedef enum logic [2:0] {
    StIdle, StWfetch, StWload, StGap, StXfetch, StExec, StDrain, StDone
  } state_e;

  state_e              state_q, state_d;
  logic [CntW-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [addr_bw-1:0]  n_act_q, w_base_q, x_base_q, p_base_q, rd_addr;
  logic [1:0]          mode_q;
  logic [WB_LAT-1:0]   wb_vld_q, wb_vld_d;
  logic [PipeW-1:0]    wb_addr_q, wb_addr_d;
  logic [35:0]         inst_q, inst_d;
  logic                busy_q, busy_d, done_q, done_d, rd;

  always_comb begin
    state_d = state_q;
    cnt_inc = cnt_q + 1'b1;
    cnt_d   = cnt_inc;
    inst_d  = IdleInst;
    done_d  = 1'b0;
    rd      = 1'b0;
    rd_addr = p_base_q + cnt_q[addr_bw-1:0];

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (start) state_d = StWfetch;
      end
      StWfetch: begin
        if (cnt_q < CntW'(col)) begin
          inst_d[19]            = 1'b0;
          inst_d[7 +: addr_bw]  = w_base_q + cnt_q[addr_bw-1:0];
        end
        // xmem data lands one cycle after the read.
        if (cnt_q != '0) inst_d[2] = 1'b1;
        if (cnt_q == CntW'(col)) begin
          state_d = StWload;
          cnt_d   = '0;
        end
      end
      StWload: begin
        inst_d[3] = 1'b1;
        inst_d[0] = 1'b1;
        if (cnt_inc == CntW'(col)) begin
          state_d = StGap;
          cnt_d   = '0;
        end
      end
      StGap: begin
        if (cnt_inc == CntW'(LOAD_GAP)) begin
          state_d = (n_act_q != '0) ? StXfetch : StDone;
          cnt_d   = '0;
        end
      end
      StXfetch: begin
        if (cnt_q < CntW'(n_act_q)) begin
          inst_d[19]            = 1'b0;
          inst_d[7 +: addr_bw]  = x_base_q + cnt_q[addr_bw-1:0];
        end
        if (cnt_q != '0) inst_d[2] = 1'b1;
        if (cnt_q == CntW'(n_act_q)) begin
          state_d = StExec;
          cnt_d   = '0;
        end
      end
      StExec: begin
        inst_d[3] = 1'b1;
        inst_d[1] = 1'b1;
        if (cnt_inc == CntW'(n_act_q)) begin
          state_d = StDrain;
          cnt_d   = '0;
        end
      end
      StDrain: begin
        cnt_d = cnt_q;
        if (ofifo_valid && (cnt_q < CntW'(n_act_q))) begin
          rd            = 1'b1;
          inst_d[6]     = 1'b1;
          inst_d[34:33] = mode_q;
          cnt_d         = cnt_inc;
          if (cnt_inc == CntW'(n_act_q)) state_d = StDone;
        end
      end
      StDone: begin
        cnt_d = '0;
        if (wb_vld_q == '0) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Writeback overlays whatever else is issued this cycle.
    if (wb_vld_q[WB_LAT-1]) begin
      inst_d[32]           = 1'b0;
      inst_d[31]           = 1'b0;
      inst_d[20 +: addr_bw] = wb_addr_q[PipeW-1 -: addr_bw];
    end

    wb_vld_d  = (wb_vld_q << 1) | WB_LAT'(rd);
    wb_addr_d = (wb_addr_q << addr_bw) | PipeW'(rd_addr);
    busy_d    = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      n_act_q   <= '0;
      w_base_q  <= '0;
      x_base_q  <= '0;
      p_base_q  <= '0;
      mode_q    <= 2'b00;
      wb_vld_q  <= '0;
      wb_addr_q <= '0;
      inst_q    <= IdleInst;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wb_vld_q  <= wb_vld_d;
      wb_addr_q <= wb_addr_d;
      inst_q    <= inst_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (state_q == StIdle && start) begin
        n_act_q  <= n_act;
        w_base_q <= w_base;
        x_base_q <= x_base;
        p_base_q <= p_base;
        mode_q   <= sfu_mode_i;
      end
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule
